// File: rtl/array_builder.sv
// array_builder
//   Collects a stream of ELEM_W-bit elements into one packed array of
//   NUM_ELEM slots. A frame closes when the last slot is filled, or early when
//   an element arrives with in_last=1. The closed frame is then held on
//   out_arr/out_count with out_valid=1 until the consumer takes it
//   (out_valid & out_ready). Unused slots of an early-closed frame read 0.
//
// Parameters
//   ELEM_W    bit width of one element
//   NUM_ELEM  elements per array (2..16)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   element offered on in_data
//   in_data    element value
//   in_last    offered element closes the array early
//   in_ready   block accepts an element this cycle (FILL state)
//   out_arr    assembled array, element i at out_arr[i]
//   out_count  number of valid elements in out_arr
//   out_valid  out_arr/out_count valid (HOLD state)
//   out_ready  consumer takes the array
//   out_par    (only with ARRAY_BUILDER_PARITY_EN) per-element XOR parity
//
// Configuration macro: ARRAY_BUILDER_PARITY_EN adds the out_par port.

module array_builder #(
  parameter int ELEM_W   = 4,
  parameter int NUM_ELEM = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [ELEM_W-1:0]                  in_data,
  input  logic                               in_last,
  output logic                               in_ready,
  output logic [NUM_ELEM-1:0][ELEM_W-1:0]    out_arr,
  output logic [$clog2(NUM_ELEM+1)-1:0]      out_count,
  output logic                               out_valid,
`ifdef ARRAY_BUILDER_PARITY_EN
  output logic [NUM_ELEM-1:0]                out_par,
`endif
  input  logic                               out_ready
);

  localparam int CNT_W = $clog2(NUM_ELEM + 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;

  logic accept;
  logic close_frame;
  logic take;

  assign accept      = in_valid && (state_q == ST_FILL);
  // The last physical slot closes the frame even without in_last.
  assign close_frame = accept && (in_last || (idx_q == CNT_W'(NUM_ELEM - 1)));
  assign take        = (state_q == ST_HOLD) && out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_FILL) begin
      if (accept) begin
        idx_d = idx_q + CNT_W'(1);
      end
      if (close_frame) begin
        state_d = ST_HOLD;
      end
    end else begin
      if (take) begin
        state_d = ST_FILL;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // One register per slot. Slots are cleared whenever a frame is handed off,
  // so an early-closed frame naturally shows zeros above its last element.
  for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_slot
    logic [ELEM_W-1:0] slot_q, slot_d;

    always_comb begin
      slot_d = slot_q;
      if (take) begin
        slot_d = '0;
      end else if (accept && (idx_q == CNT_W'(gi))) begin
        slot_d = in_data;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign out_arr[gi] = slot_q;

`ifdef ARRAY_BUILDER_PARITY_EN
    assign out_par[gi] = ^slot_q;
`endif
  end

  // idx equals the number of accepted elements, so it doubles as the count.
  assign out_count = idx_q;
  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = (state_q == ST_FILL);

endmodule

// File: tb/tb_array_builder.sv
module tb_array_builder;

  localparam int ELEM_W   = 4;
  localparam int NUM_ELEM = 4;
  localparam int CNT_W    = $clog2(NUM_ELEM + 1);

  logic                            clk;
  logic                            rst_n;
  logic                            in_valid;
  logic [ELEM_W-1:0]               in_data;
  logic                            in_last;
  logic                            in_ready;
  logic [NUM_ELEM-1:0][ELEM_W-1:0] out_arr;
  logic [CNT_W-1:0]                out_count;
  logic                            out_valid;
  logic                            out_ready;
`ifdef ARRAY_BUILDER_PARITY_EN
  logic [NUM_ELEM-1:0]             out_par;
`endif

  int total;
  int bad;

  array_builder #(
    .ELEM_W  (ELEM_W),
    .NUM_ELEM(NUM_ELEM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_arr  (out_arr),
    .out_count(out_count),
    .out_valid(out_valid),
`ifdef ARRAY_BUILDER_PARITY_EN
    .out_par  (out_par),
`endif
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Drive one element at the current negedge and advance to the next negedge.
  task automatic send(input logic [ELEM_W-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [6:0] gap_v;
    int         k;

    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_arr",   32'(out_arr),   32'h0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame, consumer always ready
    out_ready = 1'b1;
    send(4'h0, 1'b0);
    send(4'hA, 1'b0);
    send(4'h3, 1'b0);
    chk("full_not_yet_valid", 32'(out_valid), 32'd0);
    send(4'hF, 1'b0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_out_arr",   32'(out_arr),   32'hF3A0);
    chk("full_out_count", 32'(out_count), 32'd4);
    chk("full_in_ready0", 32'(in_ready),  32'd0);
`ifdef ARRAY_BUILDER_PARITY_EN
    chk("full_out_par",   32'(out_par),   32'b0000);
`endif
    @(negedge clk);
    chk("full_valid_drop", 32'(out_valid), 32'd0);
    chk("full_in_ready1",  32'(in_ready),  32'd1);
    chk("full_cleared",    32'(out_arr),   32'h0);

    // Early close
    send(4'h5, 1'b0);
    send(4'h9, 1'b1);
    chk("early_out_valid", 32'(out_valid), 32'd1);
    chk("early_out_arr",   32'(out_arr),   32'h0095);
    chk("early_out_count", 32'(out_count), 32'd2);
    @(negedge clk);
    chk("early_handshake", 32'(out_valid), 32'd0);

    // Backpressure: held frame ignores input pulses while out_ready=0
    out_ready = 1'b0;
    send(4'h8, 1'b0);
    send(4'h6, 1'b0);
    send(4'hC, 1'b0);
    send(4'h1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_arr",   32'(out_arr),   32'h1C68);
      chk("bp_out_count", 32'(out_count), 32'd4);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      send(4'hF, i[0]);
    end
    out_ready = 1'b1;
    idle(1);
    chk("bp_handshake",  32'(out_valid), 32'd0);
    chk("bp_cleared",    32'(out_arr),   32'h0);
    idle(2);
    chk("bp_single_hs",  32'(out_valid), 32'd0);
    chk("bp_idx_reset",  32'(out_count), 32'd0);

    // Gaps: in_valid pattern 1,0,0,1,1,0,1; in_last raised on gap cycles
    // must be ignored.
    gap_v = 7'b1011001; // bit i = in_valid of cycle i
    k     = 1;
    for (int i = 0; i < 7; i++) begin
      if (gap_v[i]) begin
        send(ELEM_W'(k), 1'b0);
        k++;
      end else begin
        in_valid = 1'b0;
        in_data  = 4'hE;
        in_last  = 1'b1;
        @(negedge clk);
        in_last  = 1'b0;
      end
    end
    chk("gap_out_valid", 32'(out_valid), 32'd1);
    chk("gap_out_arr",   32'(out_arr),   32'h4321);
    chk("gap_out_count", 32'(out_count), 32'd4);
    idle(1);

    // Reset mid-frame discards the partial array
    send(4'hE, 1'b0);
    send(4'hD, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_arr",   32'(out_arr),   32'h0);
    chk("mid_rst_count", 32'(out_count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    chk("mid_out_valid", 32'(out_valid), 32'd1);
    chk("mid_out_arr",   32'(out_arr),   32'h4321);
    chk("mid_out_count", 32'(out_count), 32'd4);
    idle(1);

`ifdef ARRAY_BUILDER_PARITY_EN
    send(4'h1, 1'b0);
    send(4'h7, 1'b0);
    send(4'h0, 1'b0);
    send(4'h2, 1'b0);
    chk("par_out_arr", 32'(out_arr), 32'h2071);
    chk("par_out_par", 32'(out_par), 32'b1011);
    idle(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/array_builder.md
ARRAY_BUILDER -- requirements
Module: array_builder

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 4, giving the bit width of one array element.
REQ-002 The block SHALL have parameter NUM_ELEM, default 4, giving the element count per array (legal range 2..16).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1, an element is offered on in_data.
REQ-006 The block SHALL have port in_data, input, ELEM_W, the offered element value.
REQ-007 The block SHALL have port in_last, input, 1, the offered element closes the current array early.
REQ-008 The block SHALL have port in_ready, output, 1, the block accepts an element this cycle.
REQ-009 The block SHALL have port out_arr, output, packed [NUM_ELEM-1:0][ELEM_W-1:0], the assembled array; element i sits at out_arr[i].
REQ-010 The block SHALL have port out_count, output, $clog2(NUM_ELEM+1), the number of valid elements in out_arr.
REQ-011 The block SHALL have port out_valid, output, 1, out_arr and out_count are valid.
REQ-012 The block SHALL have port out_ready, input, 1, the downstream consumer takes the array.

Function
REQ-013 The block SHALL implement a two-state FSM with states FILL and HOLD.
REQ-014 In FILL, in_ready SHALL be 1; in HOLD, in_ready SHALL be 0.
REQ-015 An element SHALL be accepted only in a cycle with in_valid=1 and in_ready=1; it SHALL be written to slot idx, and idx SHALL then increment by 1.
REQ-016 FILL SHALL go to HOLD on the clock edge that accepts either the element with idx=NUM_ELEM-1 or any element with in_last=1.
REQ-017 On an early close (in_last=1 with idx<NUM_ELEM-1), slots idx+1..NUM_ELEM-1 SHALL read 0 in out_arr.
REQ-018 out_count SHALL equal the number of elements accepted in the frame, from 1 to NUM_ELEM.
REQ-019 out_valid SHALL be 1 exactly while in HOLD; it SHALL assert the cycle after the closing element is accepted (latency 1).
REQ-020 In HOLD, out_arr and out_count SHALL stay stable until out_valid=1 and out_ready=1 occur in the same cycle.
REQ-021 On that handshake, the FSM SHALL return to FILL with idx=0, and all slots SHALL be cleared to 0 at the same edge.
REQ-022 The minimum period per full array SHALL be NUM_ELEM+1 cycles.
REQ-023 in_valid=0 cycles in FILL SHALL leave idx and the stored slots unchanged.
REQ-024 in_last SHALL be ignored when in_valid=0 or in_ready=0.
REQ-025 out_ready in FILL SHALL have no effect.

Reset
REQ-026 While rst_n=0 at a clock edge, the block SHALL enter FILL with idx=0, every slot 0, out_arr=0, out_count=0, out_valid=0, and in_ready=1 after release.
REQ-027 Reset asserted mid-frame or in HOLD SHALL discard the partial or held array with no handshake.
REQ-028 The block SHALL hold no asynchronous reset logic.

Configuration
REQ-029 With macro ARRAY_BUILDER_PARITY_EN defined, the block SHALL add port out_par, output, NUM_ELEM bits, where out_par[i] is the XOR reduction of out_arr[i], valid under the same rules as out_arr and 0 after reset.
REQ-030 Without ARRAY_BUILDER_PARITY_EN, out_par SHALL NOT exist and no parity logic SHALL be built.

Verification (ELEM_W=4, NUM_ELEM=4)
REQ-031 Full frame: send 0x0,0xA,0x3,0xF on consecutive cycles with out_ready=1 -> out_valid=1 for one cycle with out_arr=16'hF3A0 and out_count=4; in_ready is 0 that cycle and 1 the next.
REQ-032 Early close: send 0x5 then 0x9 with in_last=1 -> out_arr=16'h0095, out_count=2.
REQ-033 Backpressure: full frame with out_ready=0 for 5 cycles -> out_valid, out_arr and out_count stay stable; in_ready=0 and in_valid pulses are ignored; one handshake then occurs on out_ready=1.
REQ-034 Gaps: in_valid toggled 1,0,0,1,1,0,1 with data 1,2,3,4 -> out_arr=16'h4321.
REQ-035 Reset mid-frame: after 2 elements, pulse rst_n=0 for one cycle, then send 4 new elements 0x1..0x4 -> out_arr=16'h4321 and out_count=4; no stale data appears.
REQ-036 Parity (ARRAY_BUILDER_PARITY_EN defined): frame 0x0,0xA,0x3,0xF -> out_par=4'b0000; frame 0x1,0x7,0x0,0x2 -> out_par=4'b1011.
